spi_register_master: RTL and testbench
======================================

// Module: spi_register_master
// PURPOSE
//   Host-side SPI initiator for the synth register interface: serialises one register write
//   (16-bit register number, then 16-bit value, MSB first) per CS frame, mode 0.
//   Captures the 32 bits returned on MISO (sample stream) during the same frame.
//   Used by the on-board sequencer and by top-level benches to drive the synth's SPI slave.
// PARAMETERS
//   CLK_DIV   2  i_Clock cycles per SCK half-period; legal range >= 2
//   CS_SETUP  2  cycles with CS asserted and SCK low before the first SCK rise; >= 1
//   CS_HOLD   2  cycles with CS asserted after the final SCK low half; >= 1
//   CS_IDLE   4  minimum cycles with CS deasserted between frames; >= 1
// PORTS
//   i_Clock         in   1   system clock
//   i_Reset         in   1   synchronous, active-high reset
//   i_CmdValid      in   1   command request
//   o_CmdReady      out  1   command accepted when i_CmdValid && o_CmdReady
//   i_CmdRegNumber  in   16  register number, frame bits [31:16]
//   i_CmdRegValue   in   16  register value, frame bits [15:0]
//   o_RspValid      out  1   one-cycle pulse: o_RspData valid
//   o_RspData       out  32  MISO bits of the completed frame, first bit received in [31]
//   o_Busy          out  1   high from acceptance to end of the CS_IDLE gap
//   o_SPI_CS        out  1   chip select, active-low
//   o_SPI_SCK       out  1   serial clock, idles low
//   o_SPI_MOSI      out  1   serial data out
//   i_SPI_MISO      in   1   serial data in, asynchronous
// BEHAVIOUR
//   Reset values: o_CmdReady=0 during reset, 1 on the first cycle after; o_SPI_CS=1, o_SPI_SCK=0,
//     o_SPI_MOSI=0, o_RspValid=0, o_RspData=0, o_Busy=0.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE: o_CmdReady=1. On handshake, latch {RegNumber,RegValue} into a 32-bit shift register.
//     Next cycle: SETUP.
//   o_CmdReady=0 in every state except IDLE. Command inputs are ignored outside the handshake cycle.
//   SETUP: CS=0, SCK=0, MOSI=frame[31], held for CS_SETUP cycles.
//   SHIFT: 32 bits. Each bit is CLK_DIV cycles SCK=1, then CLK_DIV cycles SCK=0.
//     MOSI advances to the next bit on the cycle SCK drops, so data is stable across each rising edge.
//     MOSI=0 after the 32nd fall.
//   MISO path: 2-flop synchroniser. A bit is shifted into the capture register on the last cycle
//     of each SCK-high half (synchronised value).
//   HOLD: CS=0, SCK=0 for CS_HOLD cycles.
//   Frame length: CS is low for exactly CS_SETUP + 64*CLK_DIV + CS_HOLD cycles.
//   Completion: on the first CS=1 cycle, o_RspValid=1 for one cycle with o_RspData updated.
//     o_RspData holds its value until the next completion.
//   GAP: CS=1 for CS_IDLE cycles, then IDLE.
//   Back-to-back: i_CmdValid held high through GAP is accepted on the first IDLE cycle,
//     giving a CS-high gap of exactly CS_IDLE+1 cycles.
//   Reset mid-frame: next cycle CS=1, SCK=0, MOSI=0. Partial frame and capture are discarded;
//     no o_RspValid.
//   Counters: the half-period counter spans 0..CLK_DIV-1; the bit counter spans 0..31
//     (no wrap into a 33rd bit).
// STRUCTURE
//   synth.svh gains `SPI_FRAME_BITS (32) and `SPI_REG_NUMBER_BITS / `SPI_REG_VALUE_BITS (16).
//     The synth SPI slave uses the same constants.
//   Sub-module spi_sck_timer: counts CLK_DIV and emits rise/fall/last-high strobes.
//     The top keeps the FSM, shift/capture registers and synchroniser.
// TESTING (CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_IDLE=4)
//   1. Write 0x1203/0x0007 -> slave model samples 0x12030007 on 32 SCK rises;
//      CS low exactly 132 cycles; one o_RspValid pulse.
//   2. Slave model drives 0xA5A55A5A on MISO (updates on SCK fall) -> o_RspData=0xA5A55A5A.
//   3. i_CmdValid held for two commands (0x4005/0xBEEF, 0x0100/0x1234) -> two intact frames;
//      CS-high gap = 5 cycles; o_CmdReady=0 throughout each frame.
//   4. Change i_CmdRegValue 0x1111->0x2222 one cycle after the handshake -> frame carries 0x1111.
//   5. Assert i_Reset during bit 10 -> next cycle CS=1, SCK=0, MOSI=0; no o_RspValid;
//      the following write 0x4005/0xBEEF completes correctly.
//   6. CLK_DIV=5 rerun of test 1 -> CS low 2+320+2 cycles; SCK high/low halves exactly 5 cycles each.

Source files
------------

// File: rtl/spi_register_master_pkg.sv
// Shared constants and types for the SPI register-write initiator.
// The frame layout constants match those used by the synth SPI slave.
package spi_register_master_pkg;

    localparam int SPI_FRAME_BITS      = 32;
    localparam int SPI_REG_NUMBER_BITS = 16;
    localparam int SPI_REG_VALUE_BITS  = 16;
    localparam int BIT_CNT_W           = $clog2(SPI_FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [SPI_FRAME_BITS-1:0] pack_frame(
        input logic [SPI_REG_NUMBER_BITS-1:0] reg_number,
        input logic [SPI_REG_VALUE_BITS-1:0]  reg_value
    );
        return {reg_number, reg_value};
    endfunction

endpackage

// File: rtl/spi_sck_timer.sv
// SCK generator: each half-period lasts CLK_DIV cycles while run is high.
// Strobes flag the last cycle of a high half and the last cycle of a bit.
module spi_sck_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic start,
    input  logic run,
    input  logic last_bit,
    output logic sck,
    output logic last_high,
    output logic bit_end
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] half_cnt;
    logic             half_done;

    assign half_done = run && (half_cnt == CNT_LAST);
    assign last_high = half_done && sck;
    assign bit_end   = half_done && !sck;

    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (start) begin
            half_cnt <= '0;
            sck      <= 1'b1;
        end else if (run) begin
            if (half_done) begin
                half_cnt <= '0;
                // The final low half is not followed by another rise.
                sck      <= sck ? 1'b0 : !last_bit;
            end else begin
                half_cnt <= half_cnt + CNT_W'(1);
            end
        end else begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_register_master.sv
// Host-side SPI mode-0 initiator: one 32-bit register write per CS frame,
// capturing the 32 MISO bits returned during the same frame.
module spi_register_master
    import spi_register_master_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic                           i_CmdValid,
    output logic                           o_CmdReady,
    input  logic [SPI_REG_NUMBER_BITS-1:0] i_CmdRegNumber,
    input  logic [SPI_REG_VALUE_BITS-1:0]  i_CmdRegValue,
    output logic                           o_RspValid,
    output logic [SPI_FRAME_BITS-1:0]      o_RspData,
    output logic                           o_Busy,
    output logic                           o_SPI_CS,
    output logic                           o_SPI_SCK,
    output logic                           o_SPI_MOSI,
    input  logic                           i_SPI_MISO
);

    localparam int PHASE_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);
    localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(CS_SETUP - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(CS_HOLD - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(CS_IDLE - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(SPI_FRAME_BITS - 1);

    state_e                    state_q, state_d;
    logic [PHASE_W-1:0]        phase_q;
    logic [BIT_CNT_W-1:0]      bit_q;
    logic [SPI_FRAME_BITS-1:0] shift_q;
    logic [SPI_FRAME_BITS-1:0] capture_q;
    logic                      miso_meta, miso_sync;
    logic                      cs_q;
    logic                      rsp_valid_q;
    logic [SPI_FRAME_BITS-1:0] rsp_data_q;

    logic handshake, timer_start, last_bit, last_high, bit_end, sck, frame_done;

    assign o_CmdReady = (state_q == ST_IDLE) && !i_Reset;
    assign handshake  = i_CmdValid && o_CmdReady;
    assign last_bit   = (bit_q == BIT_LAST);
    assign frame_done = (state_q == ST_HOLD) && (state_d == ST_GAP);

    assign o_Busy     = (state_q != ST_IDLE);
    assign o_SPI_CS   = cs_q;
    assign o_SPI_SCK  = sck;
    // Zeros are shifted in behind the frame, so MOSI returns to 0 after the last bit.
    assign o_SPI_MOSI = shift_q[SPI_FRAME_BITS-1];
    assign o_RspValid = rsp_valid_q;
    assign o_RspData  = rsp_data_q;

    spi_sck_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_timer (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .start     (timer_start),
        .run       (state_q == ST_SHIFT),
        .last_bit  (last_bit),
        .sck       (sck),
        .last_high (last_high),
        .bit_end   (bit_end)
    );

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_start = 1'b0;
        case (state_q)
            ST_IDLE:  if (handshake) state_d = ST_SETUP;
            ST_SETUP: if (phase_q == SETUP_LAST) begin
                          state_d     = ST_SHIFT;
                          timer_start = 1'b1;
                      end
            ST_SHIFT: if (bit_end && last_bit) state_d = ST_HOLD;
            ST_HOLD:  if (phase_q == HOLD_LAST) state_d = ST_GAP;
            ST_GAP:   if (phase_q == GAP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: the synchroniser and capture register are reset as well, so nothing from an aborted frame survives.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            capture_q   <= '0;
            miso_meta   <= 1'b0;
            miso_sync   <= 1'b0;
            cs_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            miso_meta <= i_SPI_MISO;
            miso_sync <= miso_meta;
            cs_q      <= !(state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD});

            if ((state_d == state_q) && (state_q inside {ST_SETUP, ST_HOLD, ST_GAP}))
                phase_q <= phase_q + PHASE_W'(1);
            else
                phase_q <= '0;

            if (bit_end)
                bit_q <= last_bit ? '0 : bit_q + BIT_CNT_W'(1);

            // Capture on the last high cycle; MOSI advances on the same edge SCK falls.
            if (handshake) begin
                shift_q   <= pack_frame(i_CmdRegNumber, i_CmdRegValue);
                capture_q <= '0;
            end else if (last_high) begin
                shift_q   <= {shift_q[SPI_FRAME_BITS-2:0], 1'b0};
                capture_q <= {capture_q[SPI_FRAME_BITS-2:0], miso_sync};
            end

            rsp_valid_q <= frame_done;
            if (frame_done)
                rsp_data_q <= capture_q;
        end
    end

endmodule

// File: tb/tb_spi_register_master.sv
// Self-checking bench: an SPI slave model on the pins, checked against frame-level expectations.
module tb_spi_register_master;

    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int IDLE  = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, miso, sel;
    logic [15:0] cmd_num, cmd_val;

    logic        a_ready, a_rsp_valid, a_busy, a_cs, a_sck, a_mosi;
    logic [31:0] a_rsp_data;
    logic        b_ready, b_rsp_valid, b_busy, b_cs, b_sck, b_mosi;
    logic [31:0] b_rsp_data;

    spi_register_master #(.CLK_DIV(2), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_CmdValid(cmd_valid && !sel), .o_CmdReady(a_ready),
        .i_CmdRegNumber(cmd_num), .i_CmdRegValue(cmd_val), .o_RspValid(a_rsp_valid),
        .o_RspData(a_rsp_data), .o_Busy(a_busy), .o_SPI_CS(a_cs), .o_SPI_SCK(a_sck),
        .o_SPI_MOSI(a_mosi), .i_SPI_MISO(miso));

    spi_register_master #(.CLK_DIV(5), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_CmdValid(cmd_valid && sel), .o_CmdReady(b_ready),
        .i_CmdRegNumber(cmd_num), .i_CmdRegValue(cmd_val), .o_RspValid(b_rsp_valid),
        .o_RspData(b_rsp_data), .o_Busy(b_busy), .o_SPI_CS(b_cs), .o_SPI_SCK(b_sck),
        .o_SPI_MOSI(b_mosi), .i_SPI_MISO(miso));

    logic        m_ready, m_rsp_valid, m_busy, m_cs, m_sck, m_mosi;
    logic [31:0] m_rsp_data;
    always_comb begin
        m_ready     = sel ? b_ready     : a_ready;
        m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
        m_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
        m_busy      = sel ? b_busy      : a_busy;
        m_cs        = sel ? b_cs        : a_cs;
        m_sck       = sel ? b_sck       : a_sck;
        m_mosi      = sel ? b_mosi      : a_mosi;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave model and pin monitor, evaluated on the falling clock edge.
    logic [31:0] miso_word = '0;
    logic [31:0] mosi_rx = '0, last_rx = '0, end_rsp_data = '0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, end_rsp_valid = 1'b0, end_mosi = 1'b0, end_busy = 1'b0;
    int cs_low_cnt = 0, last_cs_low = 0, rises = 0, last_rises = 0, hi_len = 0, lo_len = 0;
    int half_bad = 0, rsp_pulses = 0, frames_done = 0, cs_high_run = 0, last_gap = 0;
    int ready_in_frame = 0, miso_idx = 0;

    always @(negedge clk) begin
        if (m_rsp_valid === 1'b1) rsp_pulses++;
        if (m_cs === 1'b0 && m_ready === 1'b1) ready_in_frame++;
        if (m_cs === 1'b0) begin
            if (prev_cs) begin
                last_gap   = cs_high_run;
                cs_low_cnt = 0;
                rises      = 0;
                mosi_rx    = '0;
                hi_len     = 0;
                lo_len     = 0;
                miso       = miso_word[31];
                miso_idx   = 30;
            end
            cs_low_cnt++;
            if (m_sck && !prev_sck) begin
                mosi_rx = {mosi_rx[30:0], m_mosi};
                if (rises > 0 && lo_len != (sel ? 5 : 2)) half_bad++;
                rises++;
                hi_len = 0;
            end
            if (!m_sck && prev_sck) begin
                if (hi_len != (sel ? 5 : 2)) half_bad++;
                lo_len = 0;
                if (miso_idx >= 0) begin
                    miso = miso_word[miso_idx];
                    miso_idx--;
                end
            end
            if (m_sck) hi_len++; else lo_len++;
        end else begin
            if (!prev_cs) begin
                last_rx       = mosi_rx;
                last_cs_low   = cs_low_cnt;
                last_rises    = rises;
                end_rsp_valid = m_rsp_valid;
                end_rsp_data  = m_rsp_data;
                end_mosi      = m_mosi;
                end_busy      = m_busy;
                frames_done++;
                miso          = 1'b0;
                cs_high_run   = 0;
            end
            cs_high_run++;
        end
        prev_cs  = m_cs;
        prev_sck = m_sck;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Raise valid and wait for the handshake; valid is left high for the caller.
    task automatic send_cmd(input logic [15:0] num, input logic [15:0] val);
        bit accepted;
        accepted  = 1'b0;
        cmd_num   = num;
        cmd_val   = val;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            if (m_ready) begin
                @(posedge clk);
                accepted = 1'b1;
            end
            tick();
        end
        check("handshake_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic wait_frames(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (frames_done >= target) done = 1'b1;
            else tick();
        end
        check("frame_timeout", 32'(done), 32'd1);
    endtask

    task automatic verify_frame(input string t, input logic [31:0] exp_frame,
                                input logic [31:0] exp_rsp, input int div, input int pulses0);
        check({t, "_mosi_frame"}, last_rx, exp_frame);
        check({t, "_cs_low_cycles"}, 32'(last_cs_low), 32'(SETUP + 64 * div + HOLD));
        check({t, "_sck_rises"}, 32'(last_rises), 32'd32);
        check({t, "_rsp_valid_at_cs_rise"}, 32'(end_rsp_valid), 32'd1);
        check({t, "_rsp_data"}, end_rsp_data, exp_rsp);
        check({t, "_mosi_after_frame"}, 32'(end_mosi), 32'd0);
        check({t, "_busy_in_gap"}, 32'(end_busy), 32'd1);
        check({t, "_rsp_pulses"}, 32'(rsp_pulses), 32'(pulses0 + 1));
        check({t, "_half_period_errors"}, 32'(half_bad), 32'd0);
        check({t, "_ready_inside_frame"}, 32'(ready_in_frame), 32'd0);
    endtask

    task automatic single_write(input string t, input logic [15:0] num, input logic [15:0] val,
                                input logic [31:0] mw, input int div);
        int n0, p0;
        n0 = frames_done;
        p0 = rsp_pulses;
        miso_word = mw;
        send_cmd(num, val);
        cmd_valid = 1'b0;
        wait_frames(n0 + 1);
        verify_frame(t, {num, val}, mw, div, p0);
        repeat (IDLE) tick();
        check({t, "_busy_after_gap"}, 32'(m_busy), 32'd0);
        check({t, "_ready_after_gap"}, 32'(m_ready), 32'd1);
        check({t, "_rsp_data_held"}, m_rsp_data, mw);
    endtask

    initial begin
        logic [15:0] rn, rv;
        int n0, p0;
        bit reached;
        sel = 1'b0; rst = 1'b1; cmd_valid = 1'b0; cmd_num = '0; cmd_val = '0; miso = 1'b0;

        repeat (3) tick();
        check("reset_ready", 32'(m_ready), 32'd0);
        check("reset_cs", 32'(m_cs), 32'd1);
        check("reset_sck", 32'(m_sck), 32'd0);
        check("reset_mosi", 32'(m_mosi), 32'd0);
        check("reset_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("reset_rsp_data", m_rsp_data, 32'd0);
        check("reset_busy", 32'(m_busy), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", 32'(m_ready), 32'd1);

        single_write("t1", 16'h1203, 16'h0007, $urandom, 2);
        single_write("t2", 16'($urandom), 16'($urandom), 32'hA5A55A5A, 2);

        // Back-to-back: valid stays high across both commands.
        n0 = frames_done;
        p0 = rsp_pulses;
        miso_word = $urandom;
        send_cmd(16'h4005, 16'hBEEF);
        cmd_num = 16'h0100;
        cmd_val = 16'h1234;
        wait_frames(n0 + 1);
        verify_frame("t3a", 32'h4005BEEF, miso_word, 2, p0);
        send_cmd(16'h0100, 16'h1234);
        cmd_valid = 1'b0;
        wait_frames(n0 + 2);
        verify_frame("t3b", 32'h01001234, miso_word, 2, p0 + 1);
        check("t3_cs_high_gap", 32'(last_gap), 32'(IDLE + 1));
        repeat (IDLE) tick();

        // Command inputs change right after acceptance.
        n0 = frames_done;
        p0 = rsp_pulses;
        miso_word = $urandom;
        send_cmd(16'h0042, 16'h1111);
        cmd_val   = 16'h2222;
        cmd_valid = 1'b0;
        wait_frames(n0 + 1);
        verify_frame("t4", 32'h00421111, miso_word, 2, p0);
        repeat (IDLE) tick();

        // Reset while bit 10 is on the wire.
        p0 = rsp_pulses;
        miso_word = $urandom;
        send_cmd(16'($urandom), 16'($urandom));
        cmd_valid = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (rises == 11 && m_cs == 1'b0) reached = 1'b1;
            else tick();
        end
        check("t5_reach_bit10", 32'(reached), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_cs_after_reset", 32'(m_cs), 32'd1);
        check("t5_sck_after_reset", 32'(m_sck), 32'd0);
        check("t5_mosi_after_reset", 32'(m_mosi), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("t5_no_rsp_pulse", 32'(rsp_pulses), 32'(p0));
        check("t5_rsp_data_cleared", m_rsp_data, 32'd0);
        single_write("t5_after", 16'h4005, 16'hBEEF, $urandom, 2);

        for (int k = 0; k < 4; k++) begin
            rn = 16'($urandom);
            rv = 16'($urandom);
            single_write($sformatf("rand%0d", k), rn, rv, $urandom, 2);
        end

        sel = 1'b1;
        tick();
        single_write("t6", 16'h1203, 16'h0007, $urandom, 5);
        single_write("t6_rand", 16'($urandom), 16'($urandom), $urandom, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
